axi_ad9963_up_arb: RTL and testbench

- Two-requester arbiter for the shared up_* register bus that feeds the AD9963 rx/tx register banks.
- Requester 0 is the AXI-side up interface. Requester 1 is an internal master, e.g. a calibration/IODELAY tuning sequencer.
- Serializes all reads and writes: one transaction outstanding on the slave side at a time.
- Grants fairly (round-robin) and terminates hung transactions by timeout so neither requester can lock the bus.

---
 rtl/axi_ad9963_up_arb.sv | 185 ++++++++++++++++++
 tb/tb_axi_ad9963_up_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ad9963_up_arb.sv
// Round-robin arbiter serializing two up_* masters onto one register bus, with a
// per-transaction timeout so a missing slave ack can never lock either master out.
module axi_ad9963_up_arb #(
  parameter int          ADDR_WIDTH     = 14,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic                  m0_wreq,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_wack,
  input  logic                  m0_rreq,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rack,
  input  logic                  m1_wreq,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_wack,
  input  logic                  m1_rreq,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rack,
  output logic                  s_wreq,
  output logic [ADDR_WIDTH-1:0] s_waddr,
  output logic [31:0]           s_wdata,
  input  logic                  s_wack,
  output logic                  s_rreq,
  output logic [ADDR_WIDTH-1:0] s_raddr,
  input  logic [31:0]           s_rdata,
  input  logic                  s_rack,
  output logic                  up_timeout,
  output logic [7:0]            up_timeout_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES);

  state_t state, state_nxt;

  logic [1:0]            wreq_in, rreq_in;
  logic [ADDR_WIDTH-1:0] waddr_in [2];
  logic [ADDR_WIDTH-1:0] raddr_in [2];
  logic [31:0]           wdata_in [2];

  logic [1:0]            wv, rv;
  logic [ADDR_WIDTH-1:0] wa [2];
  logic [ADDR_WIDTH-1:0] ra [2];
  logic [31:0]           wd [2];

  logic                  last_grant, gnt, gnt_rd;
  logic [15:0]           timer;
  logic [1:0]            wack_r, rack_r;
  logic [31:0]           rdata_r [2];

  logic [1:0]            pending;
  logic                  sel, sel_wr, match, expire, issue, done;

  assign wreq_in     = {m1_wreq, m0_wreq};
  assign rreq_in     = {m1_rreq, m0_rreq};
  assign waddr_in[0] = m0_waddr;
  assign waddr_in[1] = m1_waddr;
  assign raddr_in[0] = m0_raddr;
  assign raddr_in[1] = m1_raddr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;

  assign m0_wack  = wack_r[0];
  assign m1_wack  = wack_r[1];
  assign m0_rack  = rack_r[0];
  assign m1_rack  = rack_r[1];
  assign m0_rdata = rdata_r[0];
  assign m1_rdata = rdata_r[1];

  always_ff @(posedge up_clk) begin
    if (!up_rstn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    pending   = wv | rv;
    sel       = (pending == 2'b11) ? ~last_grant : pending[1];
    sel_wr    = wv[sel];
    match     = gnt_rd ? s_rack : s_wack;
    // A matching ack in the expiry cycle completes normally rather than timing out.
    expire    = (timer == TIMEOUT_LAST) && !match;
    issue     = 1'b0;
    done      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (|pending) begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (match || expire) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      wv               <= '0;
      rv               <= '0;
      last_grant       <= 1'b1;
      gnt              <= 1'b0;
      gnt_rd           <= 1'b0;
      timer            <= '0;
      wack_r           <= '0;
      rack_r           <= '0;
      s_wreq           <= 1'b0;
      s_rreq           <= 1'b0;
      s_waddr          <= '0;
      s_wdata          <= '0;
      s_raddr          <= '0;
      up_timeout       <= 1'b0;
      up_timeout_count <= '0;
      for (int i = 0; i < 2; i++) begin
        wa[i]      <= '0;
        ra[i]      <= '0;
        wd[i]      <= '0;
        rdata_r[i] <= '0;
      end
    end else begin
      s_wreq     <= 1'b0;
      s_rreq     <= 1'b0;
      wack_r     <= '0;
      rack_r     <= '0;
      up_timeout <= 1'b0;

      // A request is dropped if its slot is still occupied; the first one wins.
      for (int i = 0; i < 2; i++) begin
        if (wreq_in[i] && !wv[i]) begin
          wv[i] <= 1'b1;
          wa[i] <= waddr_in[i];
          wd[i] <= wdata_in[i];
        end
        if (rreq_in[i] && !rv[i]) begin
          rv[i] <= 1'b1;
          ra[i] <= raddr_in[i];
        end
      end

      if (issue) begin
        if (sel_wr) begin
          wv[sel] <= 1'b0;
          s_wreq  <= 1'b1;
          s_waddr <= wa[sel];
          s_wdata <= wd[sel];
        end else begin
          rv[sel] <= 1'b0;
          s_rreq  <= 1'b1;
          s_raddr <= ra[sel];
        end
        last_grant <= sel;
        gnt        <= sel;
        gnt_rd     <= ~sel_wr;
        timer      <= '0;
      end

      if (state == WAIT) begin
        if (done) begin
          if (gnt_rd) begin
            rack_r[gnt]  <= 1'b1;
            rdata_r[gnt] <= match ? s_rdata : TIMEOUT_RDATA;
          end else begin
            wack_r[gnt] <= 1'b1;
          end
          if (expire) begin
            up_timeout <= 1'b1;
            if (up_timeout_count != 8'hFF) up_timeout_count <= up_timeout_count + 8'd1;
          end
        end else begin
          timer <= timer + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_ad9963_up_arb.sv
// Bench for axi_ad9963_up_arb: directed latency/timeout/reset steps, then random
// two-master traffic scored against a transaction-level arbitration model.
module tb_axi_ad9963_up_arb;

  localparam int AW = 14;
  localparam int TO = 4;

  logic          up_clk = 1'b0, up_rstn = 1'b0;
  logic          m0_wreq = 1'b0, m0_rreq = 1'b0, m1_wreq = 1'b0, m1_rreq = 1'b0;
  logic [AW-1:0] m0_waddr = '0, m0_raddr = '0, m1_waddr = '0, m1_raddr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic          m0_wack, m0_rack, m1_wack, m1_rack;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_wreq, s_rreq;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [31:0]   s_wdata;
  logic          s_wack = 1'b0, s_rack = 1'b0;
  logic [31:0]   s_rdata = '0;
  logic          up_timeout;
  logic [7:0]    up_timeout_count;

  axi_ad9963_up_arb #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .TIMEOUT_RDATA(32'hDEAD_DEAD)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .m0_wreq(m0_wreq), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wack(m0_wack),
    .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rack(m0_rack),
    .m1_wreq(m1_wreq), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wack(m1_wack),
    .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rack(m1_rack),
    .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wack(s_wack),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rack(s_rack),
    .up_timeout(up_timeout), .up_timeout_count(up_timeout_count)
  );

  always #5 up_clk = ~up_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one write slot and one read slot per master.
  logic          mwv [2], mrv [2], swv [2], srv [2];
  logic [AW-1:0] mwa [2], mra [2];
  logic [31:0]   mwd [2];
  logic          model_last, pend, pend_rd, pend_g, ack_now, ack_rd, ack_g, g, wr, seen;
  logic [1:0]    dw, dr, p;
  logic [AW-1:0] daw [2], dar [2];
  logic [31:0]   ddw [2], ack_data;
  logic [3:0]    exp_ack;
  int            cd, issued, completed;

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    up_rstn = 1'b0;
    tick();
    up_rstn = 1'b1;
  endtask

  function automatic logic [31:0] acks();
    return 32'({m1_rack, m1_wack, m0_rack, m0_wack});
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_sreq",  32'({s_wreq, s_rreq}), 32'd0);
    chk("rst_addr",  32'({s_waddr, s_raddr}), 32'd0);
    chk("rst_acks",  acks(), 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rst_tocnt", 32'(up_timeout_count), 32'd0);
    up_rstn = 1'b1;

    // m0 write, slave acks two cycles after s_wreq
    m0_waddr = 14'h0044; m0_wdata = 32'h1234_5678; m0_wreq = 1'b1;
    tick(); m0_wreq = 1'b0;
    chk("wr_c1_sreq", 32'(s_wreq), 32'd0);
    tick();
    chk("wr_c2_sreq", 32'({s_wreq, s_rreq}), 32'd2);
    chk("wr_c2_addr", 32'(s_waddr), 32'h0044);
    chk("wr_c2_data", s_wdata, 32'h1234_5678);
    tick();
    chk("wr_c3_sreq", 32'(s_wreq), 32'd0);
    tick(); s_wack = 1'b1;
    tick(); s_wack = 1'b0;
    chk("wr_c5_ack", acks(), 32'd1);
    tick();
    chk("wr_c6_ack", acks(), 32'd0);

    // simultaneous reads: m0 first after reset, m1 right after m0_rack
    pulse_reset();
    m0_raddr = 14'h0010; m1_raddr = 14'h0020; m0_rreq = 1'b1; m1_rreq = 1'b1;
    tick(); m0_rreq = 1'b0; m1_rreq = 1'b0;
    tick();
    chk("rr_c2_sreq", 32'({s_wreq, s_rreq}), 32'd1);
    chk("rr_c2_addr", 32'(s_raddr), 32'h0010);
    tick(); s_rack = 1'b1; s_rdata = 32'hA;
    tick(); s_rack = 1'b0;
    chk("rr_c4_ack", acks(), 32'd2);
    chk("rr_c4_rd0", m0_rdata, 32'hA);
    tick();
    chk("rr_c5_sreq", 32'(s_rreq), 32'd1);
    chk("rr_c5_addr", 32'(s_raddr), 32'h0020);
    tick(); s_rack = 1'b1; s_rdata = 32'hB;
    tick(); s_rack = 1'b0; s_rdata = 32'h0;
    chk("rr_c7_ack", acks(), 32'd8);
    chk("rr_c7_rd1", m1_rdata, 32'hB);
    repeat (3) tick();
    chk("rr_hold", {m0_rdata[15:0], m1_rdata[15:0]}, 32'h000A_000B);

    // m1 write+read same cycle: write first, zero-latency acks
    pulse_reset();
    m1_waddr = 14'h0100; m1_wdata = 32'hCAFE_0001; m1_raddr = 14'h0200;
    m1_wreq = 1'b1; m1_rreq = 1'b1;
    tick(); m1_wreq = 1'b0; m1_rreq = 1'b0;
    tick();
    chk("wr1_kind", 32'({s_wreq, s_rreq}), 32'd2);
    chk("wr1_addr", 32'(s_waddr), 32'h0100);
    s_wack = 1'b1;
    tick(); s_wack = 1'b0;
    chk("wr1_ack", acks(), 32'd4);
    tick();
    chk("rd1_kind", 32'({s_wreq, s_rreq}), 32'd1);
    chk("rd1_addr", 32'(s_raddr), 32'h0200);
    chk("wr1_hold", 32'(s_waddr), 32'h0100);
    s_rack = 1'b1; s_rdata = 32'h77;
    tick(); s_rack = 1'b0;
    chk("rd1_ack", acks(), 32'd8);
    chk("rd1_data", m1_rdata, 32'h77);

    // timeout on a read, then a late ack is ignored
    pulse_reset();
    m0_raddr = 14'h0030; m0_rreq = 1'b1;
    tick(); m0_rreq = 1'b0;
    repeat (5) tick();
    chk("to_c6_ack", acks(), 32'd0);
    chk("to_c6_to",  32'(up_timeout), 32'd0);
    tick();
    chk("to_c7_ack",  acks(), 32'd2);
    chk("to_c7_data", m0_rdata, 32'hDEAD_DEAD);
    chk("to_c7_to",   32'(up_timeout), 32'd1);
    chk("to_c7_cnt",  32'(up_timeout_count), 32'd1);
    s_rack = 1'b1; s_rdata = 32'h99;
    tick(); s_rack = 1'b0;
    chk("to_late_ack",  acks(), 32'd0);
    chk("to_late_data", m0_rdata, 32'hDEAD_DEAD);
    chk("to_late_to",   32'(up_timeout), 32'd0);
    tick();

    // ack in the exact expiry cycle wins
    m0_raddr = 14'h0031; m0_rreq = 1'b1;
    tick(); m0_rreq = 1'b0;
    repeat (5) tick();
    s_rack = 1'b1; s_rdata = 32'h55;
    tick(); s_rack = 1'b0;
    chk("edge_ack",  acks(), 32'd2);
    chk("edge_data", m0_rdata, 32'h55);
    chk("edge_to",   32'(up_timeout), 32'd0);
    chk("edge_cnt",  32'(up_timeout_count), 32'd1);

    // reset while waiting with another slot pending
    m0_waddr = 14'h0001; m1_waddr = 14'h0002; m0_wdata = 32'h11; m1_wdata = 32'h22;
    m0_wreq = 1'b1; m1_wreq = 1'b1;
    tick(); m0_wreq = 1'b0; m1_wreq = 1'b0;
    tick();
    chk("rw_issue", 32'(s_wreq), 32'd1);
    tick();
    up_rstn = 1'b0;
    tick();
    up_rstn = 1'b1;
    chk("rw_sreq",  32'({s_wreq, s_rreq}), 32'd0);
    chk("rw_addr",  32'({s_waddr, s_raddr}), 32'd0);
    chk("rw_wdata", s_wdata, 32'd0);
    chk("rw_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rw_cnt",   32'(up_timeout_count), 32'd0);
    s_wack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      s_wack = 1'b0;
      seen = seen | s_wreq | s_rreq | (acks() != 0);
    end
    chk("rw_quiet", 32'(seen), 32'd0);

    // random traffic against the transaction-level model
    pulse_reset();
    model_last = 1'b1; pend = 1'b0; pend_rd = 1'b0; pend_g = 1'b0; cd = 0;
    issued = 0; completed = 0;
    for (int j = 0; j < 2; j++) begin
      mwv[j] = 1'b0; mrv[j] = 1'b0; mwa[j] = '0; mra[j] = '0; mwd[j] = '0;
    end
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 2; j++) begin
        dw[j]  = (i < 560) && ($urandom_range(0, 99) < 35);
        dr[j]  = (i < 560) && ($urandom_range(0, 99) < 35);
        daw[j] = AW'($urandom);
        dar[j] = AW'($urandom);
        ddw[j] = $urandom;
      end
      m0_wreq = dw[0]; m0_waddr = daw[0]; m0_wdata = ddw[0]; m0_rreq = dr[0]; m0_raddr = dar[0];
      m1_wreq = dw[1]; m1_waddr = daw[1]; m1_wdata = ddw[1]; m1_rreq = dr[1]; m1_raddr = dar[1];
      ack_now = 1'b0; ack_rd = pend_rd; ack_g = pend_g; ack_data = $urandom;
      if (pend) begin
        if (cd == 0) begin
          ack_now = 1'b1;
          pend = 1'b0;
          if (pend_rd) begin s_rack = 1'b1; s_rdata = ack_data; end
          else s_wack = 1'b1;
        end else cd--;
      end
      for (int j = 0; j < 2; j++) begin swv[j] = mwv[j]; srv[j] = mrv[j]; end
      tick();
      m0_wreq = 1'b0; m0_rreq = 1'b0; m1_wreq = 1'b0; m1_rreq = 1'b0;
      s_wack = 1'b0; s_rack = 1'b0;

      exp_ack = '0;
      if (ack_now) begin
        exp_ack[{ack_g, ack_rd}] = 1'b1;
        completed++;
      end
      chk("rnd_ack", acks(), 32'(exp_ack));
      if (ack_now && ack_rd) chk("rnd_rdata", ack_g ? m1_rdata : m0_rdata, ack_data);

      if (s_wreq || s_rreq) begin
        p = {swv[1] | srv[1], swv[0] | srv[0]};
        chk("rnd_spurious", 32'(p != 2'b00), 32'd1);
        chk("rnd_overlap",  32'(pend), 32'd0);
        g  = (p == 2'b11) ? ~model_last : p[1];
        wr = swv[g];
        chk("rnd_kind", 32'({s_wreq, s_rreq}), wr ? 32'd2 : 32'd1);
        if (wr) begin
          chk("rnd_waddr", 32'(s_waddr), 32'(mwa[g]));
          chk("rnd_wdata", s_wdata, mwd[g]);
          mwv[g] = 1'b0;
        end else begin
          chk("rnd_raddr", 32'(s_raddr), 32'(mra[g]));
          mrv[g] = 1'b0;
        end
        model_last = g; pend = 1'b1; pend_g = g; pend_rd = !wr;
        cd = $urandom_range(0, TO - 1);
        issued++;
      end

      for (int j = 0; j < 2; j++) begin
        if (dw[j] && !swv[j]) begin mwv[j] = 1'b1; mwa[j] = daw[j]; mwd[j] = ddw[j]; end
        if (dr[j] && !srv[j]) begin mrv[j] = 1'b1; mra[j] = dar[j]; end
      end
    end
    chk("rnd_drained", 32'({mwv[0], mwv[1], mrv[0], mrv[1], pend}), 32'd0);
    chk("rnd_balance", 32'(issued), 32'(completed));
    chk("rnd_volume",  32'(issued > 40), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
